mac_rx_header_parser: RTL
=========================

Name: mac_rx_header_parser

Overview:
- Sits directly downstream of the MAC receive CRC-verify stage, in the logic_clk domain.
- Consumes the verified Ethernet frame stream (destination MAC onward, FCS already removed, error flag on last byte).
- Strips the 14-byte Ethernet header, filters on destination MAC and EtherType, and forwards only the payload with header sideband to the ARP/IP layers.
- Counts dropped frames.

Parameters:
- ALLOW_BROADCAST, 1, 1 = accept dst FF:FF:FF:FF:FF:FF in addition to local_mac_in.
- TYPE_A, 16'h0800, first accepted EtherType (IPv4).
- TYPE_B, 16'h0806, second accepted EtherType (ARP).

Ports:
- logic_clk  in  1  single clock; all logic on rising edge.
- logic_rst  in  1  synchronous, active-low reset.
- local_mac_in  in  48  station MAC, byte 0 = [47:40]; quasi-static.
- mac_rdata_in  in  8  frame byte from CRC-verify stage.
- mac_rvalid_in  in  1  byte valid.
- mac_rready_out  out  1  byte accepted when valid & ready.
- mac_rlast_in  in  1  last byte of frame.
- mac_ruser_in  in  1  CRC/PHY error flag; meaningful only with mac_rlast_in.
- eth_rdata_out  out  8  payload byte.
- eth_rvalid_out  out  1  payload valid.
- eth_rready_in  in  1  downstream ready.
- eth_rlast_out  out  1  last payload byte.
- eth_ruser_out  out  1  frame error, valid with eth_rlast_out.
- eth_type_out  out  16  EtherType of current frame.
- eth_src_mac_out  out  48  source MAC of current frame.
- eth_hdr_valid_out  out  1  one-cycle pulse when header accepted.
- frame_drop_cnt_out  out  16  saturating drop counter.

Behaviour:
- Reset (logic_rst=0 at edge):
  - All outputs 0; FSM to HDR; byte counter 0.
  - Any in-flight frame is abandoned.
  - After reset, bytes are treated as the start of a new frame; the team guarantees reset is released between frames.
- Handshake: a transfer occurs on a cycle with valid & ready. eth_rvalid_out, once high, holds data, last and user stable until eth_rready_in.
- FSM HDR:
  - mac_rready_out=1 for header bytes 0..12.
  - Byte counter 0..13: bytes 0-5 shift into dst, 6-11 into src, 12-13 into type (byte 12 = MSB).
  - At byte 13, mac_rready_out = !eth_rvalid_out, i.e. the stage stalls until the output register has drained, so sideband never changes under a pending beat.
  - On accepting byte 13 without last, evaluate:
    - dst_ok = (dst==local_mac_in) | (ALLOW_BROADCAST & dst==48'hFFFF_FFFF_FFFF).
    - type_ok = type==TYPE_A | type==TYPE_B.
  - If both ok: go to PAYLOAD. Next cycle, load eth_type_out and eth_src_mac_out, and pulse eth_hdr_valid_out for exactly 1 cycle.
  - Else: go to DROP and increment the drop counter.
  - Runt: mac_rlast_in accepted at any header byte 0..13 (including a zero-payload frame) → increment the drop counter, stay in HDR, reset the counter to 0.
- FSM PAYLOAD:
  - mac_rready_out = !eth_rvalid_out | eth_rready_in.
  - Each accepted byte registers into the output: 1-cycle latency, full throughput when eth_rready_in=1.
  - eth_rlast_out = mac_rlast_in and eth_ruser_out = mac_ruser_in & mac_rlast_in, both registered with the data.
  - On accepting last → HDR, counter 0. The next header may be consumed while the last payload beat still waits in the output register.
- FSM DROP:
  - mac_rready_out=1; bytes discarded; eth_rvalid_out is not asserted by this frame.
  - On accepting last → HDR.
- Error frames that pass the filter are forwarded with eth_ruser_out=1 and not counted as drops.
- frame_drop_cnt_out: +1 per dropped or runt frame; saturates at 16'hFFFF, never wraps.
- eth_type_out and eth_src_mac_out hold their values until the next accepted header.
- Gaps in mac_rvalid_in at any point: state and counter hold.

Test Plan:
- Unicast IPv4 frame: dst=local_mac_in=00:0A:35:01:02:03, type 0800, 46-byte payload 00..2D, eth_rready_in=1 → 46 beats 00..2D, last on 2D, ruser=0. eth_hdr_valid_out pulses once. eth_type_out=0800. eth_src_mac_out equals the sent src. Drop count 0.
- Broadcast ARP, 28-byte payload, with ALLOW_BROADCAST=1 → forwarded, eth_type_out=0806. Same frame with ALLOW_BROADCAST=0 → no output beats, drop count 1.
- Filter rejects:
  - Wrong dst 00:0A:35:01:02:04 → no output, drop count +1.
  - Type 86DD → no output, drop count +1.
  - In both cases mac_rready_out stays 1 through the frame.
- Runt frame of 10 bytes with last on byte 9, then a valid frame → drop count +1, and the second frame is forwarded intact (counter re-aligned).
- Backpressure: eth_rready_in toggles 1010…, and an errored frame (mac_ruser_in=1 on last) is sent back-to-back with the next frame → payload order and values preserved. No beat changes while stalled. Last beat carries ruser=1. Byte 13 of the next header is not accepted until the output register is empty.
- Drop counter preset near max: 65537 rejected frames → frame_drop_cnt_out=FFFF and holds. A reset mid-payload → all outputs 0, and the next frame parses correctly.

Source files
------------

// File: rtl/mac_rx_header_parser.sv
// mac_rx_header_parser: strips the Ethernet header, filters on dst MAC and EtherType, forwards payload
//   logic_clk/logic_rst          : clock, synchronous active-low reset
//   local_mac_in                 : station MAC (byte 0 in [47:40])
//   mac_r{data,valid,ready,last,user} : verified frame stream in (user = error, with last)
//   eth_r{data,valid,ready,last,user} : payload stream out, one register stage
//   eth_type_out/eth_src_mac_out : sideband of the last accepted header
//   eth_hdr_valid_out            : one-cycle pulse per accepted header
//   frame_drop_cnt_out           : saturating count of filtered and runt frames
module mac_rx_header_parser #(
  parameter bit          ALLOW_BROADCAST = 1'b1,
  parameter logic [15:0] TYPE_A          = 16'h0800,
  parameter logic [15:0] TYPE_B          = 16'h0806
) (
  input  logic        logic_clk,
  input  logic        logic_rst,
  input  logic [47:0] local_mac_in,
  input  logic [7:0]  mac_rdata_in,
  input  logic        mac_rvalid_in,
  output logic        mac_rready_out,
  input  logic        mac_rlast_in,
  input  logic        mac_ruser_in,
  output logic [7:0]  eth_rdata_out,
  output logic        eth_rvalid_out,
  input  logic        eth_rready_in,
  output logic        eth_rlast_out,
  output logic        eth_ruser_out,
  output logic [15:0] eth_type_out,
  output logic [47:0] eth_src_mac_out,
  output logic        eth_hdr_valid_out,
  output logic [15:0] frame_drop_cnt_out
);
  typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [47:0] dst_q, src_q, src_out_q;
  logic [7:0]  type_hi_q, data_q;
  logic [15:0] type_full, eth_type_q, drop_q;
  logic        out_valid_q, last_q, user_q, hdr_valid_q;
  logic        acc, dst_ok, type_ok, accept_hdr, drop_inc, load_beat;
  assign type_full = {type_hi_q, mac_rdata_in};
  assign dst_ok    = (dst_q == local_mac_in) | (ALLOW_BROADCAST & (&dst_q));
  assign type_ok   = (type_full == TYPE_A) | (type_full == TYPE_B);
  // byte 13 waits for an empty output register so the sideband never moves under a pending beat
  assign mac_rready_out = logic_rst & (state_q == PAYLOAD ? (!out_valid_q | eth_rready_in) :
                                       state_q == HDR && cnt_q == 4'd13 ? !out_valid_q : 1'b1);
  assign acc = mac_rvalid_in & mac_rready_out;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept_hdr = 1'b0;
    drop_inc   = 1'b0;
    load_beat  = 1'b0;
    case (state_q)
      HDR: if (acc) begin
        cnt_d = cnt_q + 4'd1;
        if (mac_rlast_in) begin
          cnt_d    = 4'd0;
          drop_inc = 1'b1;
        end else if (cnt_q == 4'd13) begin
          cnt_d      = 4'd0;
          accept_hdr = dst_ok & type_ok;
          drop_inc   = !(dst_ok & type_ok);
          state_d    = (dst_ok & type_ok) ? PAYLOAD : DROP;
        end
      end
      PAYLOAD: begin
        load_beat = acc;
        if (acc && mac_rlast_in) state_d = HDR;
      end
      DROP: if (acc && mac_rlast_in) state_d = HDR;
      default: state_d = HDR;
    endcase
  end
  always_ff @(posedge logic_clk) begin
    if (!logic_rst) begin
      state_q     <= HDR;
      cnt_q       <= 4'd0;
      dst_q       <= 48'd0;
      src_q       <= 48'd0;
      type_hi_q   <= 8'd0;
      src_out_q   <= 48'd0;
      eth_type_q  <= 16'd0;
      hdr_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= 8'd0;
      last_q      <= 1'b0;
      user_q      <= 1'b0;
      drop_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_valid_q <= accept_hdr;
      if (acc && state_q == HDR) begin
        if (cnt_q < 4'd6) dst_q <= {dst_q[39:0], mac_rdata_in};
        else if (cnt_q < 4'd12) src_q <= {src_q[39:0], mac_rdata_in};
        else if (cnt_q == 4'd12) type_hi_q <= mac_rdata_in;
      end
      if (accept_hdr) begin
        eth_type_q <= type_full;
        src_out_q  <= src_q;
      end
      if (load_beat) begin
        out_valid_q <= 1'b1;
        data_q      <= mac_rdata_in;
        last_q      <= mac_rlast_in;
        user_q      <= mac_ruser_in & mac_rlast_in;
      end else if (eth_rready_in) out_valid_q <= 1'b0;
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end
  assign eth_rdata_out      = data_q;
  assign eth_rvalid_out     = out_valid_q;
  assign eth_rlast_out      = last_q;
  assign eth_ruser_out      = user_q;
  assign eth_type_out       = eth_type_q;
  assign eth_src_mac_out    = src_out_q;
  assign eth_hdr_valid_out  = hdr_valid_q;
  assign frame_drop_cnt_out = drop_q;
endmodule
